// File: rtl/alu_pkg.sv
// ALU shared definitions: FSM states, opcode map
// and the status flag bundle.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_ADC  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_SBB  = 5'h03;
    localparam logic [4:0] OP_INC  = 5'h04;
    localparam logic [4:0] OP_DEC  = 5'h05;
    localparam logic [4:0] OP_NEG  = 5'h06;
    localparam logic [4:0] OP_CMP  = 5'h07;
    localparam logic [4:0] OP_AND  = 5'h08;
    localparam logic [4:0] OP_OR   = 5'h09;
    localparam logic [4:0] OP_XOR  = 5'h0A;
    localparam logic [4:0] OP_NAND = 5'h0B;
    localparam logic [4:0] OP_NOR  = 5'h0C;
    localparam logic [4:0] OP_XNOR = 5'h0D;
    localparam logic [4:0] OP_NOT  = 5'h0E;
    localparam logic [4:0] OP_PASA = 5'h0F;
    localparam logic [4:0] OP_PASB = 5'h10;
    localparam logic [4:0] OP_SHL  = 5'h11;
    localparam logic [4:0] OP_SHR  = 5'h12;
    localparam logic [4:0] OP_ASR  = 5'h13;
    localparam logic [4:0] OP_ROL  = 5'h14;
    localparam logic [4:0] OP_ROR  = 5'h15;
    localparam logic [4:0] OP_RCL  = 5'h16;
    localparam logic [4:0] OP_RCR  = 5'h17;
    localparam logic [4:0] OP_MUL  = 5'h18;
    localparam logic [4:0] OP_MULH = 5'h19;

    typedef struct packed {
        logic carry;
        logic borrow;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_if.sv
// ALU request/result bundle; the requester drives
// operands and the start strobe, the ALU returns results.
interface alu_if;
    logic [4:0] opcode;
    logic [7:0] operand_A;
    logic [7:0] operand_B;
    logic       enable;
    logic       input_ready;
    logic       carry_in;
    logic       borrow_in;
    logic [7:0] result_out;
    logic       carry_out;
    logic       borrow_out;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       result_ready;

    modport master (
        output opcode, operand_A, operand_B,
        output enable, input_ready,
        output carry_in, borrow_in,
        input  result_out, carry_out, borrow_out,
        input  zero, negative, overflow, result_ready
    );

    modport slave (
        input  opcode, operand_A, operand_B,
        input  enable, input_ready,
        input  carry_in, borrow_in,
        output result_out, carry_out, borrow_out,
        output zero, negative, overflow, result_ready
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and status
// flags for one latched operation.
module alu_core
    import alu_pkg::*;
(
    input  logic [4:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    input  logic       bin_i,
    output logic [7:0] res_o,
    output flags_t     flags_o
);

    logic [15:0] prod;
    logic [8:0]  add9;
    logic [8:0]  sub9;
    logic [7:0]  addend;
    logic [7:0]  minu;
    logic [7:0]  subt;
    logic [7:0]  fval;
    logic        add_cin;
    logic        sub_bin;
    logic        is_add;
    logic        is_sub;
    logic        is_cmp;
    logic [7:0]  res;
    logic        carry;
    logic        borrow;
    logic        ovf;

    assign prod = {8'h00, a_i} * {8'h00, b_i};
    assign add9 = {1'b0, a_i} + {1'b0, addend}
                + {8'h00, add_cin};
    assign sub9 = {1'b0, minu} - {1'b0, subt}
                - {8'h00, sub_bin};

    // Decode opcode into operand routing and result
    always_comb begin
        addend  = b_i;
        add_cin = 1'b0;
        minu    = a_i;
        subt    = b_i;
        sub_bin = 1'b0;
        is_add  = 1'b0;
        is_sub  = 1'b0;
        is_cmp  = 1'b0;
        res     = 8'h00;
        carry   = 1'b0;
        borrow  = 1'b0;
        ovf     = 1'b0;
        case (op_i)
            OP_ADD:  is_add = 1'b1;
            OP_ADC: begin
                is_add  = 1'b1;
                add_cin = cin_i;
            end
            OP_INC: begin
                is_add = 1'b1;
                addend = 8'h01;
            end
            OP_SUB:  is_sub = 1'b1;
            OP_SBB: begin
                is_sub  = 1'b1;
                sub_bin = bin_i;
            end
            OP_DEC: begin
                is_sub = 1'b1;
                subt   = 8'h01;
            end
            OP_NEG: begin
                is_sub = 1'b1;
                minu   = 8'h00;
                subt   = a_i;
            end
            OP_CMP: begin
                is_sub = 1'b1;
                is_cmp = 1'b1;
            end
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_NAND: res = ~(a_i & b_i);
            OP_NOR:  res = ~(a_i | b_i);
            OP_XNOR: res = ~(a_i ^ b_i);
            OP_NOT:  res = ~a_i;
            OP_PASA: res = a_i;
            OP_PASB: res = b_i;
            OP_SHL: begin
                res   = {a_i[6:0], 1'b0};
                carry = a_i[7];
            end
            OP_SHR: begin
                res   = {1'b0, a_i[7:1]};
                carry = a_i[0];
            end
            OP_ASR: begin
                res   = {a_i[7], a_i[7:1]};
                carry = a_i[0];
            end
            OP_ROL: begin
                res   = {a_i[6:0], a_i[7]};
                carry = a_i[7];
            end
            OP_ROR: begin
                res   = {a_i[0], a_i[7:1]};
                carry = a_i[0];
            end
            OP_RCL: begin
                res   = {a_i[6:0], cin_i};
                carry = a_i[7];
            end
            OP_RCR: begin
                res   = {cin_i, a_i[7:1]};
                carry = a_i[0];
            end
            OP_MUL: begin
                res   = prod[7:0];
                carry = |prod[15:8];
            end
            OP_MULH: begin
                res   = prod[15:8];
                carry = |prod[15:8];
            end
            default: res = 8'h00;
        endcase
        if (is_add) begin
            res   = add9[7:0];
            carry = add9[8];
            ovf   = (a_i[7] == addend[7])
                 && (add9[7] != a_i[7]);
        end
        if (is_sub) begin
            res    = is_cmp ? a_i : sub9[7:0];
            borrow = sub9[8];
            ovf    = (minu[7] != subt[7])
                  && (sub9[7] != minu[7]);
        end
    end

    // CMP reports zero/negative of A-B, not of its result
    assign fval = is_cmp ? sub9[7:0] : res;

    assign res_o          = res;
    assign flags_o.carry  = carry;
    assign flags_o.borrow = borrow;
    assign flags_o.zero   = (fval == 8'h00);
    assign flags_o.neg    = fval[7];
    assign flags_o.ovf    = ovf;

endmodule

// File: rtl/alu.sv
// ALU top: start edge detect, IDLE/EXEC/DONE
// sequencing and registered result/flags.
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    state_t     state_q;
    logic       ir_q;
    logic       arm_q;
    logic [4:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       cin_q;
    logic       bin_q;
    logic [7:0] res_q;
    flags_t     flags_q;
    logic       rdy_q;
    logic [7:0] res_d;
    flags_t     flags_d;
    logic       start;

    // arm_q blocks a level that was already high
    // when reset released from counting as a rise
    assign start = (state_q != ST_EXEC)
                && bus.enable
                && bus.input_ready
                && !ir_q
                && arm_q;

    alu_core u_core (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .cin_i   (cin_q),
        .bin_i   (bin_q),
        .res_o   (res_d),
        .flags_o (flags_d)
    );

    // Sequence one operation per accepted start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ir_q    <= 1'b0;
            arm_q   <= 1'b0;
            op_q    <= 5'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cin_q   <= 1'b0;
            bin_q   <= 1'b0;
            res_q   <= 8'h00;
            flags_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            ir_q <= bus.input_ready;
            if (!bus.input_ready) begin
                arm_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q    <= bus.opcode;
                        a_q     <= bus.operand_A;
                        b_q     <= bus.operand_B;
                        cin_q   <= bus.carry_in;
                        bin_q   <= bus.borrow_in;
                        rdy_q   <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q   <= res_d;
                    flags_q <= flags_d;
                    rdy_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.result_out   = res_q;
    assign bus.carry_out    = flags_q.carry;
    assign bus.borrow_out   = flags_q.borrow;
    assign bus.zero         = flags_q.zero;
    assign bus.negative     = flags_q.neg;
    assign bus.overflow     = flags_q.ovf;
    assign bus.result_ready = rdy_q;

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for the ALU: expected
// results queued at issue, popped at result_ready.
module tb_alu;

    typedef struct packed {
        logic [7:0] r;
        logic [4:0] f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    alu_if bus ();

    alu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.carry_out, bus.borrow_out,
                bus.zero, bus.negative, bus.overflow};
    endfunction

    // Reference model in integer arithmetic;
    // flags packed as {carry,borrow,zero,neg,ovf}
    function automatic exp_t model(
        input logic [4:0] op,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic ci,
        input logic bi);
        int ua, ub, sa, sb2, t, st, k;
        logic [7:0] r, fv;
        logic c, bo, v;
        ua = a; ub = b;
        sa = $signed(a); sb2 = $signed(b);
        r = 0; c = 0; bo = 0; v = 0; t = 0;
        k = 0;
        fv = 0;
        case (op)
            5'h00, 5'h01, 5'h04: begin
                if (op == 5'h04) begin
                    ub = 1; sb2 = 1;
                end
                if (op == 5'h01) k = int'(ci);
                t = ua + ub + k;
                st = sa + sb2 + k;
                r = t[7:0];
                c = (t > 255);
                v = (st > 127) || (st < -128);
            end
            5'h02, 5'h03, 5'h05, 5'h06, 5'h07: begin
                if (op == 5'h05) begin
                    ub = 1; sb2 = 1;
                end
                if (op == 5'h06) begin
                    ub = ua; sb2 = sa;
                    ua = 0; sa = 0;
                end
                if (op == 5'h03) k = int'(bi);
                t = ua - ub - k;
                st = sa - sb2 - k;
                r = t[7:0];
                bo = (t < 0);
                v = (st > 127) || (st < -128);
                if (op == 5'h07) r = a;
            end
            5'h08: r = a & b;
            5'h09: r = a | b;
            5'h0A: r = a ^ b;
            5'h0B: r = ~(a & b);
            5'h0C: r = ~(a | b);
            5'h0D: r = ~(a ^ b);
            5'h0E: r = ~a;
            5'h0F: r = a;
            5'h10: r = b;
            5'h11: begin
                t = ua * 2; r = t[7:0]; c = t[8];
            end
            5'h12: begin
                t = ua / 2; r = t[7:0]; c = a[0];
            end
            5'h13: begin
                st = sa >>> 1; r = st[7:0]; c = a[0];
            end
            5'h14: begin
                t = ua * 2 + ua / 128;
                r = t[7:0]; c = a[7];
            end
            5'h15: begin
                t = ua / 2 + (ua % 2) * 128;
                r = t[7:0]; c = a[0];
            end
            5'h16: begin
                t = ua * 2 + int'(ci);
                r = t[7:0]; c = a[7];
            end
            5'h17: begin
                t = ua / 2 + int'(ci) * 128;
                r = t[7:0]; c = a[0];
            end
            5'h18, 5'h19: begin
                t = ua * ub;
                r = (op == 5'h18) ? t[7:0] : t[15:8];
                c = (t > 255);
            end
            default: r = 0;
        endcase
        fv = (op == 5'h07) ? t[7:0] : r;
        return {r, c, bo, (fv == 8'h00), fv[7], v};
    endfunction

    task automatic issue(input string tag,
                         input logic [4:0] op,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic ci,
                         input logic bi);
        int   n;
        logic got;
        exp_t e;
        @(negedge clk);
        bus.opcode      = op;
        bus.operand_A   = a;
        bus.operand_B   = b;
        bus.carry_in    = ci;
        bus.borrow_in   = bi;
        bus.enable      = 1'b1;
        bus.input_ready = 1'b0;
        @(negedge clk);
        bus.input_ready = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 8 && !got) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.result_ready) got = 1'b1;
        end
        check({tag, "_ready"}, 16'(got), 16'd1);
        check({tag, "_lat"}, 16'(n), 16'd2);
        e = sb.pop_front();
        check({tag, "_res"}, 16'(bus.result_out),
              16'(e.r));
        check({tag, "_flg"}, 16'(flags_now()),
              16'(e.f));
    endtask

    logic [4:0] t_op [0:27];
    logic [7:0] t_a  [0:27];
    logic [7:0] t_b  [0:27];
    logic       t_ci [0:27];
    logic       t_bi [0:27];

    initial begin
        int errs;
        bus.opcode      = 5'h00;
        bus.operand_A   = 8'h00;
        bus.operand_B   = 8'h00;
        bus.carry_in    = 1'b0;
        bus.borrow_in   = 1'b0;
        bus.enable      = 1'b0;
        bus.input_ready = 1'b0;

        t_op = '{5'h06, 5'h06, 5'h06, 5'h07, 5'h07,
                 5'h04, 5'h05, 5'h08, 5'h09, 5'h0A,
                 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
                 5'h10, 5'h11, 5'h12, 5'h13, 5'h15,
                 5'h16, 5'h17, 5'h19, 5'h01, 5'h03,
                 5'h02, 5'h00, 5'h1A};
        t_a  = '{8'h80, 8'h01, 8'h00, 8'h05, 8'h07,
                 8'hFF, 8'h00, 8'hF0, 8'hF0, 8'hFF,
                 8'hFF, 8'h00, 8'h0F, 8'h55, 8'h00,
                 8'h12, 8'hC1, 8'h01, 8'h80, 8'h01,
                 8'h40, 8'h02, 8'h12, 8'h7F, 8'h80,
                 8'h80, 8'h80, 8'h33};
        t_b  = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h07,
                 8'h00, 8'h00, 8'h3C, 8'h0F, 8'hFF,
                 8'hFF, 8'h00, 8'hF0, 8'h00, 8'h99,
                 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h34, 8'h00, 8'h00,
                 8'h01, 8'h80, 8'h44};
        t_ci = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 1, 0, 0, 0, 0};
        t_bi = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 1, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_res", 16'(bus.result_out), 16'h00);
        check("rst_flg", 16'(flags_now()), 16'h00);
        check("rst_rdy", 16'(bus.result_ready), 16'h0);
        rst = 1'b1;

        sb.push_back({8'h80, 5'b00011});
        issue("add", 5'h00, 8'h7F, 8'h01, 1'b0, 1'b0);
        sb.push_back({8'hF0, 5'b01010});
        issue("sub", 5'h02, 8'h10, 8'h20, 1'b0, 1'b0);
        sb.push_back({8'hFF, 5'b01010});
        issue("sbb", 5'h03, 8'h05, 8'h05, 1'b0, 1'b1);
        sb.push_back({8'h00, 5'b10100});
        issue("adc", 5'h01, 8'hFF, 8'h00, 1'b1, 1'b0);
        sb.push_back({8'h00, 5'b10100});
        issue("mul", 5'h18, 8'h10, 8'h10, 1'b0, 1'b0);

        for (int i = 0; i < 28; i++) begin
            sb.push_back(model(t_op[i], t_a[i], t_b[i],
                               t_ci[i], t_bi[i]));
            issue($sformatf("op%02h_%0d", t_op[i], i),
                  t_op[i], t_a[i], t_b[i],
                  t_ci[i], t_bi[i]);
        end

        // Held start level: one op, inputs ignored
        sb.push_back({8'h03, 5'b10000});
        issue("rol", 5'h14, 8'h81, 8'h00, 1'b0, 1'b0);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            bus.opcode    = 5'($urandom_range(0, 25));
            bus.operand_A = 8'($urandom);
            bus.operand_B = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (bus.result_ready !== 1'b1 ||
                bus.result_out !== 8'h03 ||
                bus.carry_out !== 1'b1)
                errs++;
        end
        check("hold", 16'(errs), 16'd0);

        // Start edge while disabled is ignored
        bus.input_ready = 1'b0;
        bus.enable      = 1'b0;
        @(negedge clk);
        bus.opcode      = 5'h00;
        bus.operand_A   = 8'h01;
        bus.operand_B   = 8'h01;
        bus.input_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("dis_res", 16'(bus.result_out), 16'h03);
        check("dis_rdy", 16'(bus.result_ready), 16'h1);
        check("dis_flg", 16'(flags_now()), 16'h10);

        // Reset mid-EXEC aborts, then needs a new rise
        bus.enable      = 1'b1;
        bus.input_ready = 1'b0;
        bus.opcode      = 5'h00;
        bus.operand_A   = 8'h7F;
        bus.operand_B   = 8'h01;
        @(negedge clk);
        bus.input_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ar_res", 16'(bus.result_out), 16'h00);
        check("ar_flg", 16'(flags_now()), 16'h00);
        check("ar_rdy", 16'(bus.result_ready), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("ar_nostart", 16'(bus.result_ready), 16'h0);
        check("ar_nores", 16'(bus.result_out), 16'h00);

        sb.push_back({8'h00, 5'b00100});
        issue("op1f", 5'h1F, 8'hAA, 8'h55, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 5 bits: operation select.
REQ-004 SHALL have ports operand_A and operand_B, inputs, 8 bits each: unsigned/two's-complement operands.
REQ-005 SHALL have port enable, input, 1 bit: start requests are ignored while 0.
REQ-006 SHALL have port input_ready, input, 1 bit: start request; its 0->1 transition is the trigger.
REQ-007 SHALL have ports carry_in and borrow_in, inputs, 1 bit each: carry for ADC/RCL/RCR, borrow for SBB.
REQ-008 SHALL have port result_out, output, 8 bits, registered: operation result.
REQ-009 SHALL have ports carry_out, borrow_out, zero, negative, overflow, outputs, 1 bit each, registered: status flags.
REQ-010 SHALL have port result_ready, output, 1 bit, registered: result valid.

Function
REQ-011 SHALL implement a state machine with states IDLE, EXEC, DONE.
REQ-012 Start is accepted when state is IDLE or DONE, enable=1, input_ready=1 and input_ready was 0 at the previous edge; a level held high SHALL start only one operation.
REQ-013 On acceptance: latch opcode, operands, carry_in, borrow_in; clear result_ready; go to EXEC.
REQ-014 In EXEC, the next edge SHALL register result and all flags, set result_ready=1 and go to DONE (latency: result valid 2 edges after input_ready rises).
REQ-015 In DONE, result_ready and all outputs SHALL hold until the next accepted start or reset.
REQ-016 Input changes outside acceptance SHALL NOT affect an operation in progress or held outputs.
REQ-017 Opcodes: 00 ADD A+B; 01 ADC A+B+cin; 02 SUB A-B; 03 SBB A-B-bin; 04 INC A+1; 05 DEC A-1; 06 NEG 0-A; 07 CMP (result=A, flags from A-B).
REQ-018 Opcodes: 08 AND; 09 OR; 0A XOR; 0B NAND; 0C NOR; 0D XNOR; 0E NOT A; 0F PASS A; 10 PASS B.
REQ-019 Opcodes: 11 SHL; 12 SHR logical; 13 ASR; 14 ROL; 15 ROR; 16 RCL (cin into bit0); 17 RCR (cin into bit7); all by 1 bit on A.
REQ-020 Opcodes: 18 MUL, result=(A*B)[7:0]; 19 MULH, result=(A*B)[15:8]; both unsigned.
REQ-021 Opcodes 1A-1F are undefined: result=0, zero=1, other flags 0, result_ready still asserted.
REQ-022 Add ops (ADD, ADC, INC): carry_out=9th sum bit; overflow=(A[7]==B'[7]) and result[7]!=A[7], B' the addend; borrow_out=0.
REQ-023 Sub ops (SUB, SBB, DEC, NEG, CMP): borrow_out=1 iff unsigned minuend < subtrahend (+bin); overflow=(minuend[7]!=subtrahend[7]) and result[7]!=minuend[7]; carry_out=0; NEG overflow=1 only for A=0x80.
REQ-024 Shifts/rotates: carry_out=bit shifted out; overflow=0; borrow_out=0.
REQ-025 MUL/MULH: carry_out=1 iff product[15:8]!=0; overflow=0; borrow_out=0.
REQ-026 Logic/PASS ops: carry_out, borrow_out, overflow=0.
REQ-027 zero=(result==0), negative=result[7] for every opcode; CMP flags SHALL use A-B value, not result.
REQ-028 All arithmetic wraps modulo 256.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, result_out=0x00, carry_out=borrow_out=negative=overflow=0, zero=0, result_ready=0, input_ready history=0.
REQ-030 Reset mid-EXEC SHALL abort the operation; after release, input_ready already high SHALL NOT start until it falls and rises again.

Structure
REQ-031 Opcode constants and state encoding SHALL reside in package alu_pkg.
REQ-032 Combinational result/flag computation SHALL be sub-module alu_core; alu holds FSM, edge detect and output registers.

Verification
REQ-033 ADD A=0x7F, B=0x01 -> result 0x80, overflow=1, negative=1, carry_out=0, result_ready 2 edges after input_ready rise.
REQ-034 SUB A=0x10, B=0x20 -> result 0xF0, borrow_out=1, negative=1; SBB A=0x05, B=0x05, bin=1 -> 0xFF, borrow_out=1.
REQ-035 ADC A=0xFF, B=0x00, cin=1 -> result 0x00, zero=1, carry_out=1; MUL A=0x10, B=0x10 -> 0x00, carry_out=1, zero=1.
REQ-036 input_ready held high 10 cycles with ROL A=0x81 -> exactly one operation, result 0x03, carry_out=1; enable=0 with input_ready rise -> no change.
REQ-037 rst asserted during EXEC -> all outputs 0 at once; opcode 0x1F -> result 0, zero=1, result_ready=1.
